// File: rtl/twiddle_mult_stream_pkg.sv
// Shared constants, payload types and helpers for the twiddle multiplier stream.
// Coefficients are signed NBITS-bit values with NBITS-2 fractional bits (1.0 = 512).
// The packed coefficient bus stores entry 0 at the MSB end and real above imag in each entry.
package twiddle_mult_stream_pkg;

    localparam int unsigned NBITS = 11;
    localparam int unsigned N     = 32;
    localparam int unsigned DW    = 16;

    localparam int unsigned IDXW  = $clog2(N);
    localparam int unsigned CW    = 2 * NBITS;
    localparam int unsigned BUSW  = NBITS * N * 2;
    localparam int unsigned PW    = DW + NBITS;
    localparam int unsigned SW    = DW + NBITS + 1;
    localparam int unsigned FRAC  = NBITS - 2;

    // Half an LSB of the output scale, added before the truncating shift.
    localparam logic signed [SW-1:0] RND = SW'(64'd1 << (FRAC - 1));

    typedef struct packed {
        logic signed [NBITS-1:0] re;
        logic signed [NBITS-1:0] im;
    } coeff_t;

    // S1 payload: the four partial products plus the frame tags.
    typedef struct packed {
        logic signed [PW-1:0] ac;
        logic signed [PW-1:0] bd;
        logic signed [PW-1:0] ad;
        logic signed [PW-1:0] bc;
        logic                 sof;
        logic                 eof;
    } s1_t;

    function automatic logic signed [SW-1:0] sat_max();
        return SW'((64'd1 << (DW - 1)) - 64'd1);
    endfunction

    function automatic logic signed [SW-1:0] sat_min();
        return ~sat_max();
    endfunction

    function automatic logic signed [DW-1:0] saturate(input logic signed [SW-1:0] x);
        if (x > sat_max()) return DW'(sat_max());
        if (x < sat_min()) return DW'(sat_min());
        return DW'(x);
    endfunction

    // Negation that maps the most negative coefficient to the most positive one.
    function automatic logic signed [NBITS-1:0] neg_sat(input logic signed [NBITS-1:0] x);
        logic signed [NBITS-1:0] mn;
        mn = {1'b1, {(NBITS-1){1'b0}}};
        return (x == mn) ? ~mn : -x;
    endfunction

    // Entry k sits at bus[2*NBITS*(N-k)-1 -: 2*NBITS].
    function automatic coeff_t coeff_entry(input logic [BUSW-1:0] bus, input logic [IDXW-1:0] k);
        return coeff_t'(bus[BUSW - 1 - CW * int'(k) -: CW]);
    endfunction

endpackage

// File: rtl/twiddle_mult_stream_if.sv
// Bundle of the coefficient bus, input sample stream and output product stream.
// master: upstream/downstream environment; slave: the multiplier block.
interface twiddle_mult_stream_if import twiddle_mult_stream_pkg::*; ();

    logic [BUSW-1:0]       coeff_data;
    logic                  cfg_inv;
    logic                  in_valid;
    logic                  in_ready;
    logic signed [DW-1:0]  in_re;
    logic signed [DW-1:0]  in_im;
    logic                  in_sof;
    logic                  out_valid;
    logic                  out_ready;
    logic signed [DW-1:0]  out_re;
    logic signed [DW-1:0]  out_im;
    logic                  out_sof;
    logic                  out_eof;

    modport master (
        output coeff_data, cfg_inv, in_valid, in_re, in_im, in_sof, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_sof, out_eof
    );

    modport slave (
        input  coeff_data, cfg_inv, in_valid, in_re, in_im, in_sof, out_ready,
        output in_ready, out_valid, out_re, out_im, out_sof, out_eof
    );

endinterface

// File: rtl/twiddle_mult_stream_cmult_round_sat.sv
// Combines two partial products (difference or sum), rounds half-up and saturates to DW bits.
// Ports: p0, p1 - partial products; sub - 1 = p0-p1, 0 = p0+p1; res_c - combinational result.
module cmult_round_sat
    import twiddle_mult_stream_pkg::*;
(
    input  logic signed [PW-1:0] p0,
    input  logic signed [PW-1:0] p1,
    input  logic                 sub,
    output logic signed [DW-1:0] res_c
);

    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] scaled;

    always_comb begin
        sum    = sub ? (SW'(p0) - SW'(p1)) : (SW'(p0) + SW'(p1));
        scaled = (sum + RND) >>> FRAC;
        res_c  = saturate(scaled);
    end

endmodule

// File: rtl/twiddle_mult_stream.sv
// Streaming complex multiply of sample k of each frame by twiddle coefficient k.
// Ports: clk, rst (async, active-high); bus - coefficient bus, cfg_inv, input and output
// valid/ready streams with frame tags. Two stages (S1 products, S2 combine/round/saturate);
// the whole pipe advances together whenever the output register is free or being drained.
module twiddle_mult_stream
    import twiddle_mult_stream_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    twiddle_mult_stream_if.slave  bus
);

    logic                    en;
    logic                    xfer;
    logic [IDXW-1:0]         k;
    logic [IDXW-1:0]         idx;
    coeff_t                  coef;
    logic signed [NBITS-1:0] c_re;
    logic signed [NBITS-1:0] c_im;
    s1_t                     s1_d;
    s1_t                     s1_q;
    logic                    s1_valid;
    logic signed [DW-1:0]    re_c;
    logic signed [DW-1:0]    im_c;

    // Global advance; held low during reset so in_ready rises only after release.
    assign en           = bus.out_ready | ~bus.out_valid;
    assign bus.in_ready = en & ~rst;
    assign xfer         = bus.in_valid & bus.in_ready;
    assign idx          = bus.in_sof ? '0 : k;

    // Coefficient select and S1 partial products.
    always_comb begin
        coef     = coeff_entry(bus.coeff_data, idx);
        c_re     = coef.re;
        c_im     = bus.cfg_inv ? neg_sat(coef.im) : coef.im;
        s1_d.ac  = PW'(bus.in_re) * PW'(c_re);
        s1_d.bd  = PW'(bus.in_im) * PW'(c_im);
        s1_d.ad  = PW'(bus.in_re) * PW'(c_im);
        s1_d.bc  = PW'(bus.in_im) * PW'(c_re);
        s1_d.sof = bus.in_sof;
        s1_d.eof = (idx == IDXW'(N - 1));
    end

    // Sample index within the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k <= '0;
        end else if (xfer) begin
            k <= (idx == IDXW'(N - 1)) ? '0 : idx + IDXW'(1);
        end
    end

    // S1 register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (en) begin
            s1_valid <= xfer;
            s1_q     <= s1_d;
        end
    end

    cmult_round_sat u_re (
        .p0    (s1_q.ac),
        .p1    (s1_q.bd),
        .sub   (1'b1),
        .res_c (re_c)
    );

    cmult_round_sat u_im (
        .p0    (s1_q.ad),
        .p1    (s1_q.bc),
        .sub   (1'b0),
        .res_c (im_c)
    );

    // S2 register drives the output stream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_re    <= '0;
            bus.out_im    <= '0;
            bus.out_sof   <= 1'b0;
            bus.out_eof   <= 1'b0;
        end else if (en) begin
            bus.out_valid <= s1_valid;
            bus.out_re    <= re_c;
            bus.out_im    <= im_c;
            bus.out_sof   <= s1_q.sof & s1_valid;
            bus.out_eof   <= s1_q.eof & s1_valid;
        end
    end

endmodule

// File: tb/tb_twiddle_mult_stream.sv
// Scoreboard bench for twiddle_mult_stream: stimulus pushes expected products, a monitor
// pops and compares on every output transfer and checks stability while stalled.
module tb_twiddle_mult_stream;
    import twiddle_mult_stream_pkg::*;

    typedef struct {
        int re;
        int im;
        bit sof;
        bit eof;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    int   mk = 0;

    twiddle_mult_stream_if ifc();

    twiddle_mult_stream dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    // Coefficient table: entries 0, 5 and 9 are the ones the directed vectors rely on.
    function automatic int coef_re(input int k);
        if (k == 0) return 512;
        if (k == 9) return 502;
        if (k == 5) return 0;
        return 512 - 8 * k;
    endfunction

    function automatic int coef_im(input int k);
        if (k == 0) return 0;
        if (k == 9) return -100;
        if (k == 5) return -1024;
        return 16 * k - 200;
    endfunction

    function automatic int clampi(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic void model(input int a, input int b, input int idx, input bit inv,
                                  output int re, output int im);
        longint c, d, pr, pi;
        c = longint'(coef_re(idx));
        d = longint'(coef_im(idx));
        if (inv) d = (d == -1024) ? 1023 : -d;
        pr = longint'(a) * c - longint'(b) * d;
        pi = longint'(a) * d + longint'(b) * c;
        re = clampi((pr + 256) >>> 9);
        im = clampi((pi + 256) >>> 9);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Present a sample and wait (bounded) until it is accepted.
    task automatic send_core(input int a, input int b, input bit sof, input bit inv,
                             output int idx, output bit ok);
        int guard;
        guard = 0;
        ifc.in_re    = DW'(a);
        ifc.in_im    = DW'(b);
        ifc.in_sof   = sof;
        ifc.cfg_inv  = inv;
        ifc.in_valid = 1'b1;
        @(negedge clk);
        while (!ifc.in_ready && guard < 50) begin
            @(posedge clk); #1;
            @(negedge clk);
            guard++;
        end
        ok  = ifc.in_ready;
        idx = sof ? 0 : mk;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end else begin
            mk = (idx == int'(N) - 1) ? 0 : idx + 1;
        end
    endtask

    task automatic send_m(input int a, input int b, input bit sof, input bit inv);
        int idx, re, im;
        bit ok;
        send_core(a, b, sof, inv, idx, ok);
        if (ok) begin
            model(a, b, idx, inv, re, im);
            q.push_back('{re, im, sof, (idx == int'(N) - 1)});
        end
        @(posedge clk); #1;
    endtask

    task automatic send_h(input int a, input int b, input bit sof, input bit inv,
                          input int hre, input int him);
        int idx;
        bit ok;
        send_core(a, b, sof, inv, idx, ok);
        if (ok) q.push_back('{hre, him, sof, (idx == int'(N) - 1)});
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        ifc.in_valid = 1'b0;
        ifc.in_sof   = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Start a frame with zero samples so the next sample lands on index n.
    task automatic to_idx(input int n);
        send_m(0, 0, 1'b1, 1'b0);
        repeat (n - 1) send_m(0, 0, 1'b0, 1'b0);
    endtask

    // Monitor: compare on every output transfer, check hold-stability while stalled.
    exp_t                 e;
    logic                 hold = 1'b0;
    logic signed [DW-1:0] h_re, h_im;
    logic                 h_sof, h_eof;

    always @(negedge clk) begin
        if (rst) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("stall_valid", ifc.out_valid, 1);
                chk("stall_re", ifc.out_re, h_re);
                chk("stall_im", ifc.out_im, h_im);
                chk("stall_tags", {ifc.out_sof, ifc.out_eof}, {h_sof, h_eof});
            end
            if (ifc.out_valid && ifc.out_ready) begin
                hold = 1'b0;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got re=%0d im=%0d expected no output",
                             ifc.out_re, ifc.out_im);
                end else begin
                    e = q.pop_front();
                    chk("out_re", ifc.out_re, e.re);
                    chk("out_im", ifc.out_im, e.im);
                    chk("out_sof", ifc.out_sof, e.sof);
                    chk("out_eof", ifc.out_eof, e.eof);
                end
            end else if (ifc.out_valid) begin
                hold  = 1'b1;
                h_re  = ifc.out_re;
                h_im  = ifc.out_im;
                h_sof = ifc.out_sof;
                h_eof = ifc.out_eof;
            end else begin
                hold = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BUSW-1:0] cb;
        logic [NBITS-1:0] r, i;
        cb = '0;
        for (int kk = 0; kk < int'(N); kk++) begin
            r = NBITS'(coef_re(kk));
            i = NBITS'(coef_im(kk));
            cb[CW * (int'(N) - kk) - 1 -: CW] = {r, i};
        end
        ifc.coeff_data = cb;
        ifc.cfg_inv    = 1'b0;
        ifc.in_valid   = 1'b0;
        ifc.in_re      = '0;
        ifc.in_im      = '0;
        ifc.in_sof     = 1'b0;
        ifc.out_ready  = 1'b1;
        rst            = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", ifc.out_valid, 0);
        chk("rst_out_re", ifc.out_re, 0);
        chk("rst_out_im", ifc.out_im, 0);
        chk("rst_out_sof", ifc.out_sof, 0);
        chk("rst_out_eof", ifc.out_eof, 0);
        chk("rst_in_ready", ifc.in_ready, 0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", ifc.in_ready, 1);

        // Identity coefficient and two-cycle latency
        send_h(100, -50, 1'b1, 1'b0, 100, -50);
        chk("lat_cycle1_valid", ifc.out_valid, 0);
        idle(1);
        chk("lat_cycle2_valid", ifc.out_valid, 1);
        idle(3);

        // Twiddle, rounding, saturation, conjugate, saturated coefficient negation
        to_idx(9); send_h(512, 0, 1'b0, 1'b0, 502, -100);
        to_idx(9); send_h(1, 0, 1'b0, 1'b0, 1, 0);
        to_idx(9); send_h(32767, 32767, 1'b0, 1'b0, 32767, 25727);
        to_idx(9); send_h(32767, 32767, 1'b0, 1'b1, 25727, 32767);
        to_idx(5); send_h(512, 0, 1'b0, 1'b1, 0, 1023);
        idle(4);

        // Two full frames, sof only on the first sample
        for (int n = 0; n < 2 * int'(N); n++)
            send_m(37 * n - 1000, 500 - 23 * n, (n == 0), 1'b0);
        idle(4);

        // Backpressure with continuous input
        fork
            begin
                for (int n = 0; n < 8; n++)
                    send_m(1000 * n - 3000, 250 * n + 7, (n == 0), n[0]);
                idle(1);
            end
            begin
                ifc.out_ready = 1'b0;
                repeat (3) @(posedge clk);
                @(negedge clk);
                chk("bp_in_ready", ifc.in_ready, 0);
                repeat (2) @(posedge clk);
                #1;
                ifc.out_ready = 1'b1;
            end
        join
        idle(4);

        // Reset with two samples in flight
        send_m(11, 22, 1'b1, 1'b0);
        send_m(33, 44, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", ifc.out_valid, 0);
        chk("midrst_out_re", ifc.out_re, 0);
        q.delete();
        mk = 0;
        ifc.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);
        send_h(512, 0, 1'b0, 1'b0, 512, 0);
        idle(5);

        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
